// File: rtl/mtm_alu_pkt_tx.sv
// Serial packet transmitter for the MTM ALU: queues commands and sends B, A and a control/CRC byte as 11-bit frames.
// Optional macro MTM_ALU_PKT_TX_CRC_INJECT_EN adds cmd_crc_err to corrupt the sent crc4 for error-path testing.
module mtm_alu_pkt_tx #(
  parameter int OPERAND_BYTES = 4,
  parameter int QUEUE_DEPTH   = 4,
  parameter int BIT_CYCLES    = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [8*OPERAND_BYTES-1:0]       cmd_a,
  input  logic [8*OPERAND_BYTES-1:0]       cmd_b,
  input  logic [2:0]                       cmd_op,
`ifdef MTM_ALU_PKT_TX_CRC_INJECT_EN
  input  logic                             cmd_crc_err,
`endif
  output logic                             sin,
  output logic                             busy,
  output logic [$clog2(QUEUE_DEPTH):0]     queue_level
);

  localparam int OPW     = 8 * OPERAND_BYTES;
  localparam int NBYTES  = 2 * OPERAND_BYTES + 1;
  localparam int PKT_W   = 8 * NBYTES;
  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 * OPW + 4;
  localparam int CNT_W   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BYTE_W  = $clog2(NBYTES);

  typedef enum logic [2:0] {IDLE, START, TYPE, DATA, STOP} state_t;

  // serial CRC, polynomial x^4+x+1, init 0, message MSB first
  function automatic logic [3:0] crc4_calc(input logic [2*OPW+3:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'd0;
    for (int i = 2*OPW+3; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2], c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  logic cmd_err;
`ifdef MTM_ALU_PKT_TX_CRC_INJECT_EN
  assign cmd_err = cmd_crc_err;
`else
  assign cmd_err = 1'b0;
`endif

  // command queue
  logic [ENTRY_W-1:0] mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]   level_reg, level_next;
  logic               ready_reg;
  logic               push, pop;

  logic [ENTRY_W-1:0] head;
  logic [OPW-1:0]     head_a, head_b;
  logic [2:0]         head_op;
  logic               head_err;
  logic [3:0]         head_crc;

  assign push = cmd_valid & ready_reg & ~rst;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {cmd_b, cmd_a, cmd_op, cmd_err};
    end
  end

  assign head     = mem[rd_ptr_reg];
  assign head_b   = head[ENTRY_W-1 -: OPW];
  assign head_a   = head[ENTRY_W-OPW-1 -: OPW];
  assign head_op  = head[3:1];
  assign head_err = head[0];
  assign head_crc = crc4_calc({head_b, head_a, 1'b1, head_op}) ^ {3'b000, head_err};

  assign level_next = level_reg + LVL_W'(push) - LVL_W'(pop);

  // transmit FSM
  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [2:0]        bit_reg, bit_next;
  logic [BYTE_W-1:0] byte_reg, byte_next;
  logic [PKT_W-1:0]  pkt_reg, pkt_next;
  logic              sin_reg, sin_next;
  logic              busy_reg, busy_next;
  logic              bit_end, queue_empty, load;
  logic [7:0]        cur_byte;

  assign bit_end     = (cnt_reg == CNT_W'(BIT_CYCLES - 1));
  assign queue_empty = (level_reg == '0);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    byte_next  = byte_reg;
    pkt_next   = pkt_reg;
    load       = 1'b0;
    sin_next   = 1'b1;
    busy_next  = 1'b0;
    cur_byte   = 8'd0;

    if (state_reg == IDLE) begin
      load = ~queue_empty;
    end else if (bit_end) begin
      cnt_next = '0;
      case (state_reg)
        START: state_next = TYPE;
        TYPE: begin
          state_next = DATA;
          bit_next   = 3'd0;
        end
        DATA: begin
          if (bit_reg == 3'd7) state_next = STOP;
          else                 bit_next   = bit_reg + 3'd1;
        end
        STOP: begin
          if (byte_reg != BYTE_W'(NBYTES - 1)) begin
            state_next = START;
            byte_next  = byte_reg + BYTE_W'(1);
            pkt_next   = pkt_reg << 8;
          end else if (!queue_empty) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end

    // a pop starts the next packet's start bit on the same edge
    if (load) begin
      state_next = START;
      cnt_next   = '0;
      byte_next  = '0;
      pkt_next   = {head_b, head_a, 1'b0, head_op, head_crc};
    end

    cur_byte = pkt_next[PKT_W-1 -: 8];
    case (state_next)
      START:   sin_next = 1'b0;
      TYPE:    sin_next = (byte_next == BYTE_W'(NBYTES - 1));
      DATA:    sin_next = cur_byte[3'd7 - bit_next];
      default: sin_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

  assign pop = load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      bit_reg    <= 3'd0;
      byte_reg   <= '0;
      sin_reg    <= 1'b1;
      busy_reg   <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ready_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      byte_reg  <= byte_next;
      sin_reg   <= sin_next;
      busy_reg  <= busy_next;
      level_reg <= level_next;
      ready_reg <= (level_next != LVL_W'(QUEUE_DEPTH));
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    pkt_reg <= pkt_next;
  end

  assign sin         = sin_reg;
  assign busy        = busy_reg;
  assign cmd_ready   = ready_reg;
  assign queue_level = level_reg;

endmodule

// File: tb/tb_mtm_alu_pkt_tx.sv
// Bench for mtm_alu_pkt_tx: a default instance (4-byte operands, 1 clock/bit) and a 2-byte, 3 clocks/bit instance.
`timescale 1ns/1ps
module tb_mtm_alu_pkt_tx;

  localparam int N0 = 4;
  localparam int N1 = 2;
  localparam int QD = 4;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic        err;
  } cmd_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [7:0]  exp_ctrl;
  } vec_t;

  typedef struct {
    logic [71:0] bytes;
    logic [8:0]  types;
    int          start_cyc;
    int          end_cyc;
    int          busy_cnt;
  } rx_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst0, v0, rdy0, sin0, busy0;
  logic [31:0] a0, b0;
  logic [2:0]  op0, lvl0;
  logic        rst1, v1, rdy1, sin1, busy1;
  logic [15:0] a1, b1;
  logic [2:0]  op1, lvl1;
`ifdef MTM_ALU_PKT_TX_CRC_INJECT_EN
  logic        err0, err1;
`endif

  mtm_alu_pkt_tx #(.OPERAND_BYTES(N0), .QUEUE_DEPTH(QD), .BIT_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst0), .cmd_valid(v0), .cmd_ready(rdy0),
    .cmd_a(a0), .cmd_b(b0), .cmd_op(op0),
`ifdef MTM_ALU_PKT_TX_CRC_INJECT_EN
    .cmd_crc_err(err0),
`endif
    .sin(sin0), .busy(busy0), .queue_level(lvl0)
  );

  mtm_alu_pkt_tx #(.OPERAND_BYTES(N1), .QUEUE_DEPTH(QD), .BIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst1), .cmd_valid(v1), .cmd_ready(rdy1),
    .cmd_a(a1), .cmd_b(b1), .cmd_op(op1),
`ifdef MTM_ALU_PKT_TX_CRC_INJECT_EN
    .cmd_crc_err(err1),
`endif
    .sin(sin1), .busy(busy1), .queue_level(lvl1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // reference: CRC as the remainder of polynomial long division of msg*x^4 by x^4+x+1
  function automatic logic [3:0] model_crc(input cmd_t c, input int nb);
    bit m[$];
    logic [4:0] poly;
    poly = 5'b10011;
    for (int i = 8*nb-1; i >= 0; i--) m.push_back(c.b[i]);
    for (int i = 8*nb-1; i >= 0; i--) m.push_back(c.a[i]);
    m.push_back(1'b1);
    for (int i = 2; i >= 0; i--) m.push_back(c.op[i]);
    repeat (4) m.push_back(1'b0);
    for (int i = 0; i + 4 < m.size(); i++)
      if (m[i]) for (int j = 0; j < 5; j++) m[i+j] = m[i+j] ^ poly[4-j];
    return {m[m.size()-4], m[m.size()-3], m[m.size()-2], m[m.size()-1]};
  endfunction

  function automatic logic [7:0] model_ctrl(input cmd_t c, input int nb);
    return {1'b0, c.op, model_crc(c, nb) ^ {3'b000, c.err}};
  endfunction

  function automatic logic [127:0] model_data(input cmd_t c, input int nb);
    logic [127:0] d;
    d = '0;
    for (int i = nb-1; i >= 0; i--) d = (d << 8) | 128'(c.b[8*i +: 8]);
    for (int i = nb-1; i >= 0; i--) d = (d << 8) | 128'(c.a[8*i +: 8]);
    return d;
  endfunction

  function automatic cmd_t mk(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op, input logic err);
    cmd_t c;
    c.a = a; c.b = b; c.op = op; c.err = err;
    return c;
  endfunction

  // frame decoder for dut0: collects 9-frame packets into rx_q
  rx_t  rx_q[$];
  rx_t  cur;
  bit   mon_en = 0;
  bit   in_frame = 0;
  int   fbit = 0, nframe = 0, stop_err = 0, idle_busy_err = 0, last_end = 0;
  logic [9:0] fr;

  always @(negedge clk) begin
    if (!mon_en || rst0) begin
      in_frame = 0;
      nframe   = 0;
    end else if (in_frame || sin0 == 1'b0) begin
      if (!in_frame) begin
        in_frame = 1;
        fbit     = 0;
        fr       = '0;
        if (nframe == 0) begin
          cur.start_cyc = cyc; cur.bytes = '0; cur.types = '0; cur.busy_cnt = 0;
        end
      end else begin
        fr = {fr[8:0], sin0};
        fbit++;
      end
      if (busy0) cur.busy_cnt++;
      if (fbit == 10) begin
        in_frame = 0;
        if (fr[0] !== 1'b1) stop_err++;
        cur.types = {cur.types[7:0], fr[9]};
        cur.bytes = {cur.bytes[63:0], fr[8:1]};
        nframe++;
        if (nframe == 2*N0+1) begin
          cur.end_cyc = cyc;
          rx_q.push_back(cur);
          nframe = 0;
        end
      end
    end else if (busy0 !== 1'b0) begin
      idle_busy_err++;
    end
  end

  task automatic push0(input cmd_t c, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    v0 = 1'b1; a0 = c.a[31:0]; b0 = c.b[31:0]; op0 = c.op;
`ifdef MTM_ALU_PKT_TX_CRC_INJECT_EN
    err0 = c.err;
`endif
    while (rdy0 !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    if (t == 3000) chk("push0 ready timeout", rdy0, 1);
    acc = cyc + 1;
    $display("push a=%h b=%h op=%0d err=%0d accept_cycle=%0d", c.a[31:0], c.b[31:0], c.op, c.err, acc);
    @(posedge clk);
  endtask

  task automatic idle0();
    @(negedge clk);
    v0 = 1'b0;
  endtask

  task automatic expect0(input cmd_t c, input logic [7:0] exp_ctrl, input int acc,
                         input bit chk_lat, input bit chk_gap, input string tag, output logic [7:0] got_ctrl);
    rx_t r;
    int t;
    logic [127:0] d;
    t = 0;
    got_ctrl = 8'hxx;
    while (rx_q.size() == 0 && t < 3000) begin @(negedge clk); t++; end
    chk({tag, " packet arrived"}, rx_q.size() != 0, 1);
    if (rx_q.size() == 0) return;
    r = rx_q.pop_front();
    d = model_data(c, N0);
    got_ctrl = r.bytes[7:0];
    chk({tag, " data bytes"}, r.bytes[71:8], d[63:0]);
    chk({tag, " ctrl byte"}, r.bytes[7:0], exp_ctrl);
    chk({tag, " type bits"}, r.types, 9'h001);
    chk({tag, " busy cycles"}, r.busy_cnt, 99);
    if (chk_lat) chk({tag, " start latency"}, r.start_cyc - acc, 1);
    if (chk_gap) chk({tag, " stop-to-start gap"}, r.start_cyc - last_end, 1);
    last_end = r.end_cyc;
    $display("packet %s bytes=%h start=%0d end=%0d busy=%0d", tag, r.bytes, r.start_cyc, r.end_cyc, r.busy_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  vec_t  vecs[5];
  cmd_t  c, cq[$];
  int    acc, accs[$], s0, quiet;
  logic [7:0] gc, gc2;
  logic  wave[170];

  initial begin
    vecs[0] = '{32'h00000001, 32'h00000002, 3'd0, 8'h00};
    vecs[1] = '{32'hDEADBEEF, 32'h12345678, 3'd1, 8'h00};
    vecs[2] = '{32'h00000000, 32'h00000000, 3'd7, 8'h00};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd5, 8'h00};
    vecs[4] = '{32'h80000001, 32'h00000080, 3'd3, 8'h00};
    for (int i = 1; i < 5; i++)
      vecs[i].exp_ctrl = model_ctrl(mk({32'h0, vecs[i].a}, {32'h0, vecs[i].b}, vecs[i].op, 1'b0), N0);

    rst0 = 1; rst1 = 1; v0 = 0; v1 = 0; a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
`ifdef MTM_ALU_PKT_TX_CRC_INJECT_EN
    err0 = 0; err1 = 0;
`endif
    repeat (3) @(negedge clk);
    chk("reset sin", sin0, 1);
    chk("reset busy", busy0, 0);
    chk("reset queue_level", lvl0, 0);
    chk("reset cmd_ready", rdy0, 1);
    chk("reset dut1 sin", sin1, 1);
    chk("reset dut1 busy", busy1, 0);
    rst0 = 0; rst1 = 0; mon_en = 1;
    @(negedge clk);

    // table-driven single packets from an idle transmitter
    for (int i = 0; i < 5; i++) begin
      c = mk({32'h0, vecs[i].a}, {32'h0, vecs[i].b}, vecs[i].op, 1'b0);
      push0(c, acc);
      idle0();
      expect0(c, vecs[i].exp_ctrl, acc, 1, 0, $sformatf("vec%0d", i), gc);
      repeat (2) @(negedge clk);
    end
    chk("idle busy after vectors", busy0, 0);

    // five back-to-back pushes: queue fills, packets chain without gaps
    for (int i = 0; i < 5; i++) begin
      c = mk({32'h0, $urandom()}, {32'h0, $urandom()}, 3'($urandom_range(0, 7)), 1'b0);
      cq.push_back(c);
      push0(c, acc);
      accs.push_back(acc);
    end
    idle0();
    chk("b2b queue_level full", lvl0, 4);
    chk("b2b cmd_ready low when full", rdy0, 0);
    for (int i = 0; i < 5; i++) begin
      c = cq.pop_front();
      acc = accs.pop_front();
      expect0(c, model_ctrl(c, N0), acc, i == 0, i != 0, $sformatf("b2b%0d", i), gc);
    end
    repeat (3) @(negedge clk);

    // random commands with random spacing
    for (int i = 0; i < 10; i++) begin
      c = mk({32'h0, $urandom()}, {32'h0, $urandom()}, 3'($urandom_range(0, 7)), 1'b0);
      cq.push_back(c);
      push0(c, acc);
      idle0();
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      c = cq.pop_front();
      expect0(c, model_ctrl(c, N0), 0, 0, 0, $sformatf("rnd%0d", i), gc);
    end
    repeat (3) @(negedge clk);

`ifdef MTM_ALU_PKT_TX_CRC_INJECT_EN
    // CRC corruption affects only its own command
    c = mk(64'h0, 64'h0, 3'd0, 1'b0);
    cq.push_back(mk({32'h0, 32'hCAFEF00D}, {32'h0, 32'h01234567}, 3'd6, 1'b1));
    cq.push_back(mk({32'h0, 32'hCAFEF00D}, {32'h0, 32'h01234567}, 3'd6, 1'b0));
    push0(cq[0], acc);
    push0(cq[1], s0);
    idle0();
    c = cq.pop_front();
    expect0(c, model_ctrl(c, N0), acc, 1, 0, "crc_err1", gc);
    c = cq.pop_front();
    expect0(c, model_ctrl(c, N0), s0, 0, 1, "crc_err0", gc2);
    chk("crc_err flips only bit 0", gc ^ model_ctrl(c, N0), 8'h01);
    repeat (3) @(negedge clk);
`endif

    // reset mid-packet with two commands still queued
    for (int i = 0; i < 3; i++) begin
      c = mk({32'h0, $urandom()}, {32'h0, $urandom()}, 3'd2, 1'b0);
      push0(c, acc);
      if (i == 0) s0 = acc + 1;
    end
    idle0();
    chk("pre-reset queue_level", lvl0, 2);
    while (cyc < s0 + 17) @(negedge clk);
    rst0 = 1; v0 = 1; a0 = 32'h55; b0 = 32'hAA; op0 = 3'd4;
    @(negedge clk);
    chk("mid-reset sin", sin0, 1);
    chk("mid-reset busy", busy0, 0);
    chk("mid-reset queue_level", lvl0, 0);
    chk("mid-reset cmd_ready", rdy0, 1);
    @(negedge clk);
    rst0 = 0; v0 = 0;
    quiet = 0;
    repeat (250) begin
      @(negedge clk);
      if (sin0 !== 1'b1 || busy0 !== 1'b0) quiet++;
    end
    chk("post-reset line activity", quiet, 0);
    chk("post-reset residual packets", rx_q.size(), 0);
    chk("post-reset queue_level", lvl0, 0);

    // dut1: 2-byte operands, 3 clocks per bit
    c = mk({48'h0, 16'hA55A}, {48'h0, 16'h0F81}, 3'd5, 1'b0);
    @(negedge clk);
    v1 = 1; a1 = c.a[15:0]; b1 = c.b[15:0]; op1 = c.op;
`ifdef MTM_ALU_PKT_TX_CRC_INJECT_EN
    err1 = 1'b0;
`endif
    chk("dut1 cmd_ready", rdy1, 1);
    $display("push dut1 a=%h b=%h op=%0d", a1, b1, op1);
    @(posedge clk);
    @(negedge clk);
    v1 = 0;
    chk("dut1 idle before start bit", sin1, 1);
    quiet = 0;
    for (int k = 0; k < 170; k++) begin
      @(negedge clk);
      wave[k] = sin1;
      if (busy1) quiet++;
    end
    begin
      logic [127:0] d;
      logic [39:0]  pk;
      logic [10:0]  seq;
      logic [32:0]  e, g;
      logic [4:0]   tail;
      d  = model_data(c, N1);
      pk = {d[31:0], model_ctrl(c, N1)};
      for (int f = 0; f < 5; f++) begin
        seq = {1'b0, f == 4, pk[39-8*f -: 8], 1'b1};
        e = '0;
        g = '0;
        for (int i = 10; i >= 0; i--) e = (e << 3) | {30'd0, {3{seq[i]}}};
        for (int s = 0; s < 33; s++) g = (g << 1) | 33'(wave[33*f + s]);
        chk($sformatf("dut1 frame%0d waveform", f), g, e);
        $display("dut1 frame%0d got=%h expected=%h", f, g, e);
      end
      for (int s = 0; s < 5; s++) tail[4-s] = wave[165 + s];
      chk("dut1 line idle after packet", tail, 5'b11111);
    end
    chk("dut1 busy cycles", quiet, 165);

    chk("dut0 stop bits", stop_err, 0);
    chk("dut0 busy while idle", idle_busy_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mtm_alu_pkt_tx.md
MTM_ALU_PKT_TX -- requirements
Module: mtm_alu_pkt_tx

Interface
REQ-001 SHALL have parameter OPERAND_BYTES, default 4; bytes per operand (1..8).
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4; command queue entries, power of 2, at least 2.
REQ-003 SHALL have parameter BIT_CYCLES, default 1; clocks per serial bit (1..16).
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  queue can accept a command.
REQ-008 SHALL have port cmd_a  input  8*OPERAND_BYTES  operand A.
REQ-009 SHALL have port cmd_b  input  8*OPERAND_BYTES  operand B.
REQ-010 SHALL have port cmd_op  input  3  ALU opcode.
REQ-011 SHALL have port sin  output  1  serial line to the ALU, idle high.
REQ-012 SHALL have port busy  output  1  a packet is being transmitted.
REQ-013 SHALL have port queue_level  output  $clog2(QUEUE_DEPTH)+1  queued commands.

Function
REQ-014 SHALL accept a command on each rising edge where cmd_valid and cmd_ready are both high; cmd_ready = queue not full.
REQ-015 SHALL NOT bypass the queue: when full, cmd_ready stays low even on a pop cycle.
REQ-016 SHALL, in IDLE with a non-empty queue, pop at the next edge and drive the start bit from that edge, giving 1 cycle from acceptance to the start bit on an empty queue.
REQ-017 SHALL use an FSM with states IDLE -> START -> TYPE -> DATA(8 bits) -> STOP -> START (more bytes remain) or IDLE/START (packet done, by queue state).
REQ-018 SHALL send each frame as 11 bits in this order: 0 (start), type bit, 8 data bits MSB-first, 1 (stop).
REQ-019 SHALL use type bit 0 for data frames and 1 for the control frame.
REQ-020 SHALL send the packet as the bytes of B (MSB byte first), then the bytes of A (MSB byte first), then the control byte {1'b0, op, crc4}.
REQ-021 SHALL compute crc4 with polynomial x^4+x+1 and init 0 over {B, A, 1'b1, op}, MSB first, at pop time.
REQ-022 SHALL hold each bit exactly BIT_CYCLES clocks, so one packet takes (2*OPERAND_BYTES+1)*11*BIT_CYCLES clocks.
REQ-023 SHALL start the next packet's start bit immediately after a stop bit when the queue is non-empty, with no idle gap.
REQ-024 SHALL drive busy high from the start bit to the end of the final stop bit, and low otherwise.
REQ-025 SHALL update queue_level on each push/pop; a simultaneous push and pop leaves it unchanged.
REQ-026 SHALL drive all outputs from registers.

Reset
REQ-027 SHALL, after reset, set sin=1, busy=0, queue_level=0, cmd_ready=1 and the FSM to IDLE.
REQ-028 SHALL, on reset mid-packet, abort the frame, drive sin=1 from the next edge and flush the queue.
REQ-029 SHALL ignore cmd_valid on a cycle where rst is high.

Configuration
REQ-030 SHALL, with macro MTM_ALU_PKT_TX_CRC_INJECT_EN defined, add port cmd_crc_err  input  1, queued with the command; when set, the sent crc4 is the computed value XOR 4'b0001.
REQ-031 SHALL, without the macro, have no cmd_crc_err port and always send the correct crc4.

Verification
REQ-032 SHALL cover: reset, then A=32'h00000001, B=32'h00000002, op=3'b000 -> start bit 1 cycle after acceptance; 9 frames; bytes 00,00,00,02,00,00,00,01; control byte op/crc matches the model; 99 cycles busy.
REQ-033 SHALL cover: 5 commands pushed back-to-back with QUEUE_DEPTH=4 and idle FSM -> cmd_ready low after 4 unpopped pushes; 5 packets sent with no gap between stop and start bits.
REQ-034 SHALL cover: BIT_CYCLES=3, OPERAND_BYTES=2 -> each bit held 3 cycles; 5 frames; packet length 165 cycles.
REQ-035 SHALL cover: rst pulsed during data bit 4 of frame 2 with 2 commands queued -> sin=1 from the next edge, busy=0, queue_level=0, no residual frames.
REQ-036 SHALL cover: macro defined, cmd_crc_err=1 -> control byte crc differs from the model only in bit 0; a following command with cmd_crc_err=0 sends the correct crc.
